// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the M-extension ops.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Quotient returned for any divide by zero.
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Rs1 is interpreted as two's complement.
  function automatic logic a_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // Rs2 is interpreted as two's complement.
  function automatic logic b_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  logic             flush;
  logic [2:0]       MulDivOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [4:0]       RdE;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] MulDivResultE;
  logic [4:0]       MulDivRdE;

  // Pipeline side: presents the op, consumes stall and result.
  modport master (
    output start, flush, MulDivOpE, SrcAE, SrcBE, RdE,
    input  busy, done, MulDivResultE, MulDivRdE
  );

  // Unit side.
  modport slave (
    input  start, flush, MulDivOpE, SrcAE, SrcBE, RdE,
    output busy, done, MulDivResultE, MulDivRdE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for RV32M. Operands are reduced to
// magnitudes on accept, one bit is processed per cycle through a single
// shared adder, and the sign fixup is applied on the way into DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_in, op_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q, result_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_res_q, neg_rem_q, done_q;

  logic               busy, accept, last_step;
  logic               a_neg, b_neg, div_zero, div_ovf, fast_path;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     shifted, add_a, add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic               div_ge;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  assign op_in = muldiv_op_t'(bus.MulDivOpE);

  // Operand signs and magnitudes for the op being offered.
  assign a_neg     = a_signed(op_in) & bus.SrcAE[WIDTH-1];
  assign b_neg     = b_signed(op_in) & bus.SrcBE[WIDTH-1];
  assign a_mag     = a_neg ? -bus.SrcAE : bus.SrcAE;
  assign b_mag     = b_neg ? -bus.SrcBE : bus.SrcBE;
  assign div_zero  = is_div(op_in) && (bus.SrcBE == '0);
  assign div_ovf   = is_div(op_in) && b_signed(op_in) &&
                     (bus.SrcAE == MIN_NEG) && (bus.SrcBE == '1);
  assign fast_path = div_zero || div_ovf;
  assign last_step = (cnt_q == CNT_W'(WIDTH-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, accept and stall request.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    busy    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_d = fast_path ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (bus.flush)     state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared adder operands: add multiplicand for shift-add, subtract divisor
  // from the shifted partial remainder for restoring division.
  assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div(op_q)) begin
      add_a   = shifted;
      add_b   = ~{1'b0, b_mag_q};
      add_cin = 1'b1;
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = acc_q[0] ? {1'b0, a_mag_q} : '0;
    end
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  assign div_ge  = add_sum[WIDTH+1];

  // One iteration of the accumulator: {hi, multiplier} or {rem, quotient}.
  always_comb begin
    acc_step = acc_q;
    if (is_div(op_q))
      acc_step = {(div_ge ? add_sum[WIDTH-1:0] : shifted[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    else
      acc_step = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
  end

  // Sign fixup and result selection from the final iteration.
  always_comb begin
    prod_fix  = neg_res_q ? -acc_step : acc_step;
    quo_fix   = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      OP_REM, OP_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  // Capture on accept, iterate in CALC, register result and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath flops are reset too, since the outputs must read zero
    // immediately on reset and an op in flight is deliberately discarded.
    if (!rst_n) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_d == DONE);
      if (accept) begin
        op_q      <= op_in;
        rd_q      <= bus.RdE;
        a_mag_q   <= a_mag;
        b_mag_q   <= b_mag;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        cnt_q     <= '0;
        acc_q     <= {{WIDTH{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
        if (div_zero)
          result_q <= is_rem(op_in) ? bus.SrcAE : WIDTH'(DIV_ZERO_Q);
        else if (div_ovf)
          result_q <= is_rem(op_in) ? '0 : MIN_NEG;
      end else if (state_q == CALC && !bus.flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_step) result_q <= final_res;
      end
    end
  end

  assign bus.busy          = busy;
  assign bus.done          = done_q;
  assign bus.MulDivResultE = result_q;
  assign bus.MulDivRdE     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model plus a
// cycle-timing expectation drive a per-cycle compare of busy/done/result.
module tb_muldiv_unit;

  localparam int          W    = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  bit          chk_en = 0;
  bit          exp_active = 0;
  bit          exp_nodone = 0;
  int          exp_start = 0;
  int          exp_done = 0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub, pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return ONES;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Per-cycle compare against the expected timing window of the current op.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic eb, ed;
      eb = exp_active && (cyc >= exp_start) && (cyc < exp_done);
      ed = exp_active && !exp_nodone && (cyc == exp_done);
      check("busy", 32'(bus.busy), 32'(eb));
      check("done", 32'(bus.done), 32'(ed));
      if (ed) begin
        check("result", bus.MulDivResultE, exp_res);
        check("rd", 32'(bus.MulDivRdE), 32'(exp_rd));
      end
    end
  end

  // Present an op in the next cycle and record when it must complete.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bit fast;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.flush     = 1'b0;
    bus.MulDivOpE = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    bus.RdE       = rd;
    fast = (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == MINV && b == ONES);
    exp_start  = cyc;
    exp_done   = cyc + (fast ? 1 : W + 1);
    exp_res    = model(op, a, b);
    exp_rd     = rd;
    exp_nodone = 0;
    exp_active = 1;
  endtask

  // Full op: start held until done, literal pins on model and DUT.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit);
    int n;
    int lat;
    start_op(op, a, b, rd);
    lat = exp_done - exp_start;
    check({name, "_model"}, exp_res, lit);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 100);
    check({name, "_done_seen"}, 32'(bus.done), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, bus.MulDivResultE, lit);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.MulDivOpE = '0;
    bus.SrcAE     = '0;
    bus.SrcBE     = '0;
    bus.RdE       = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.MulDivResultE, 32'd0);
    check("rst_rd", 32'(bus.MulDivRdE), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1;

    // Multiplies; 7 x -3 spans the full 34-cycle window.
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    idle(2);
    run_op("mulh_min_min", 3'd1, MINV, MINV, 5'd2, 32'h4000_0000);
    idle(1);
    run_op("mulhu_ones", 3'd3, ONES, ONES, 5'd3, 32'hFFFF_FFFE);
    run_op("mulhsu_m1_2", 3'd2, ONES, 32'd2, 5'd4, 32'hFFFF_FFFF);
    run_op("mulh_m5_3", 3'd1, 32'hFFFF_FFFB, 32'd3, 5'd5, 32'hFFFF_FFFF);
    idle(2);

    // Divides, back to back.
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd8, 32'd14);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd9, 32'd2);
    run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD);
    run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1);
    idle(2);

    // Fast paths: divide by zero and signed overflow.
    run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd13, 32'd5);
    run_op("div_ovf", 3'd4, MINV, ONES, 5'd14, MINV);
    run_op("rem_ovf", 3'd6, MINV, ONES, 5'd15, 32'd0);
    idle(2);

    // Flush on the tenth CALC cycle.
    start_op(3'd5, 32'hFFFF_FFF0, 32'd3, 5'd16);
    repeat (10) @(posedge clk); #1;
    bus.flush  = 1'b1;
    exp_done   = cyc + 1;
    exp_nodone = 1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy_low", 32'(bus.busy), 32'd0);
    check("flush_no_done", 32'(bus.done), 32'd0);
    repeat (5) @(posedge clk); #1;
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 5'd17, 32'd3);
    check("divu_9_3_rd", 32'(bus.MulDivRdE), 32'd17);
    idle(2);

    // Asynchronous reset in the middle of CALC.
    start_op(3'd0, 32'h1234_5678, 32'h0000_0100, 5'd21);
    repeat (5) @(posedge clk); #2;
    chk_en     = 0;
    exp_active = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.MulDivResultE, 32'd0);
    check("midrst_rd", 32'(bus.MulDivRdE), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1;
    run_op("mul_6_7", 3'd0, 32'd6, 32'd7, 5'd3, 32'd42);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
